// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER inter-stage handshake register.
// Payload bundles are packed so a stage register can carry them as one vector.
package otter_pipe_pkg;

    localparam int EM_W = 108;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_TWO
    } pipe_st_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic        mem_we;
        logic        mem_re;
        logic [1:0]  size;
        logic        sign;
    } em_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic        reg_we;
    } mw_bus_t;

    localparam int MW_W = $bits(mw_bus_t);

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit: kill beats load beats drop.
// CLR selects whether a kill also zeroes the payload.
module pipe_slot #(
    parameter int DATA_W = 108,
    parameter bit CLR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              drop,
    input  logic              kill,
    input  logic [DATA_W-1:0] d,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    logic              vld_d, vld_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (kill) begin
            vld_d = 1'b0;
            if (CLR) data_d = '0;
        end else if (ld) begin
            vld_d  = 1'b1;
            data_d = d;
        end else if (drop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld = vld_q;
    assign q   = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage register with valid/ready handshake, stall, flush,
// optional 2-entry skid buffer and saturating stall/bubble counters.
module pipe_stage_hs
    import otter_pipe_pkg::*;
#(
    parameter int DATA_W    = $bits(em_bus_t),
    parameter int SKID      = 1,
    parameter bit CLR_ON_FL = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              STALL,
    input  logic              VALID_IN,
    output logic              READY_OUT,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              VALID_OUT,
    input  logic              READY_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  BUBBLE_CNT
);

    logic              rdy_eff, xin, xout;
    logic              main_vld, main_ld, main_drop;
    logic [DATA_W-1:0] main_q, main_din;
    logic              skid_vld, skid_ld, skid_drop;
    logic [DATA_W-1:0] skid_q;
    pipe_st_t          st;

    assign rdy_eff = READY_IN & ~STALL;
    assign xin     = VALID_IN & READY_OUT;
    assign xout    = VALID_OUT & rdy_eff;

    assign st = skid_vld ? PS_TWO : (main_vld ? PS_ONE : PS_EMPTY);

    always_comb begin
        main_ld   = 1'b0;
        main_drop = 1'b0;
        main_din  = DATA_IN;
        skid_ld   = 1'b0;
        skid_drop = 1'b0;
        if (!FLUSH) begin
            unique case (st)
                PS_EMPTY: main_ld = xin;
                PS_ONE: begin
                    if (xin && !xout && (SKID != 0)) skid_ld = 1'b1;
                    else if (xin)                    main_ld = 1'b1;
                    else if (xout)                   main_drop = 1'b1;
                end
                PS_TWO: begin
                    if (xout) begin
                        main_ld   = 1'b1;
                        main_din  = skid_q;
                        skid_drop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CLR(CLR_ON_FL)) u_main (
        .clk  (CLK),
        .rst  (RST),
        .ld   (main_ld),
        .drop (main_drop),
        .kill (FLUSH),
        .d    (main_din),
        .vld  (main_vld),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_d, rdy_q;

            pipe_slot #(.DATA_W(DATA_W), .CLR(CLR_ON_FL)) u_skid (
                .clk  (CLK),
                .rst  (RST),
                .ld   (skid_ld),
                .drop (skid_drop),
                .kill (FLUSH),
                .d    (DATA_IN),
                .vld  (skid_vld),
                .q    (skid_q)
            );

            // Ready comes from a flop so upstream never sees READY_IN/STALL.
            assign rdy_d = FLUSH | ~(skid_ld | (skid_vld & ~skid_drop));

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) rdy_q <= 1'b1;
                else     rdy_q <= rdy_d;
            end

            assign READY_OUT = rdy_q;
        end else begin : g_noskid
            logic unused_skid;
            assign unused_skid = skid_ld | skid_drop;
            assign skid_vld    = 1'b0;
            assign skid_q      = '0;
            assign READY_OUT   = ~main_vld | rdy_eff;
        end
    endgenerate

    assign VALID_OUT = main_vld;
    assign DATA_OUT  = main_q;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (VALID_OUT && !rdy_eff && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (!VALID_OUT && rdy_eff && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign BUBBLE_CNT = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench: skid, no-skid and narrow-counter/hold-data instances
// share one stimulus stream; each step checks hand-computed values.
module tb_pipe_stage_hs;

    localparam int DW = 108;

    logic          clk, rst, flush, stall, vin, rin;
    logic [DW-1:0] din;

    logic          ro1, vo1, ro0, vo0, ro4, vo4;
    logic [DW-1:0] do1, do0, do4;
    logic [15:0]   sc1, bc1, sc0, bc0;
    logic [3:0]    sc4, bc4;

    int nchk = 0;
    int nerr = 0;

    pipe_stage_hs #(.DATA_W(DW), .SKID(1), .CLR_ON_FL(1'b1), .CNT_W(16)) d1 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .STALL(stall),
        .VALID_IN(vin), .READY_OUT(ro1), .DATA_IN(din),
        .VALID_OUT(vo1), .READY_IN(rin), .DATA_OUT(do1),
        .STALL_CNT(sc1), .BUBBLE_CNT(bc1)
    );

    pipe_stage_hs #(.DATA_W(DW), .SKID(0), .CLR_ON_FL(1'b1), .CNT_W(16)) d0 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .STALL(stall),
        .VALID_IN(vin), .READY_OUT(ro0), .DATA_IN(din),
        .VALID_OUT(vo0), .READY_IN(rin), .DATA_OUT(do0),
        .STALL_CNT(sc0), .BUBBLE_CNT(bc0)
    );

    pipe_stage_hs #(.DATA_W(DW), .SKID(1), .CLR_ON_FL(1'b0), .CNT_W(4)) d4 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .STALL(stall),
        .VALID_IN(vin), .READY_OUT(ro4), .DATA_IN(din),
        .VALID_OUT(vo4), .READY_IN(rin), .DATA_OUT(do4),
        .STALL_CNT(sc4), .BUBBLE_CNT(bc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        vin   = 1'b0;
        rin   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        din   = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // 1: async reset mid-stream
        rin = 1'b1; vin = 1'b1; din = DW'('hABC);
        tick();
        chk("s1_vo1", vo1, 1); chk("s1_do1", do1, 'hABC);
        chk("s1_vo0", vo0, 1); chk("s1_do0", do0, 'hABC);
        #2 rst = 1'b1;
        #1;
        chk("s1_rst_vo1", vo1, 0); chk("s1_rst_do1", do1, 0);
        chk("s1_rst_vo0", vo0, 0); chk("s1_rst_do0", do0, 0);
        chk("s1_rst_sc1", sc1, 0); chk("s1_rst_bc1", bc1, 0);
        chk("s1_rst_bc0", bc0, 0); chk("s1_rst_do4", do4, 0);
        chk("s1_rst_ro1", ro1, 1); chk("s1_rst_ro0", ro0, 1);
        vin = 1'b0; rin = 1'b0;
        tick();
        rst = 1'b0;

        // 2: streaming A..D at full rate
        vin = 1'b1; din = DW'('hA1);
        tick();
        chk("s2_A1", do1, 'hA1); chk("s2_A0", do0, 'hA1);
        rin = 1'b1; din = DW'('hB2);
        tick();
        chk("s2_B1", do1, 'hB2); chk("s2_B0", do0, 'hB2);
        din = DW'('hC3);
        tick();
        chk("s2_C1", do1, 'hC3); chk("s2_C0", do0, 'hC3);
        din = DW'('hD4);
        tick();
        chk("s2_D1", do1, 'hD4); chk("s2_D0", do0, 'hD4);
        chk("s2_bc1", bc1, 0); chk("s2_bc0", bc0, 0);
        vin = 1'b0;
        tick();
        chk("s2_end_vo1", vo1, 0); chk("s2_end_vo0", vo0, 0);

        // 3: skid absorbs B while READY_IN is low
        do_reset();
        vin = 1'b1; din = DW'('hA);
        tick();
        chk("s3_c1_do", do1, 'hA); chk("s3_c1_ro", ro1, 1);
        din = DW'('hB);
        tick();
        chk("s3_c2_do", do1, 'hA); chk("s3_c2_ro", ro1, 0);
        din = DW'('hC);
        tick();
        chk("s3_c3_ro", ro1, 0);
        tick();
        chk("s3_c4_do", do1, 'hA); chk("s3_c4_sc", sc1, 3);
        rin = 1'b1;
        tick();
        chk("s3_c5_do", do1, 'hB); chk("s3_c5_ro", ro1, 1);
        tick();
        chk("s3_c6_do", do1, 'hC); chk("s3_c6_vo", vo1, 1);
        vin = 1'b0;
        tick();
        chk("s3_c7_vo", vo1, 0); chk("s3_c7_sc", sc1, 3);

        // 4: flush with two entries held, 0x55 offered
        do_reset();
        vin = 1'b1; din = DW'('h11);
        tick();
        din = DW'('h22);
        tick();
        chk("s4_two_ro", ro1, 0); chk("s4_two_sc", sc1, 1);
        din = DW'('h55); flush = 1'b1;
        tick();
        chk("s4_fl_vo1", vo1, 0); chk("s4_fl_do1", do1, 0);
        chk("s4_fl_ro1", ro1, 1); chk("s4_fl_sc1", sc1, 2);
        chk("s4_fl_vo4", vo4, 0); chk("s4_fl_do4", do4, 'h11);
        flush = 1'b0; vin = 1'b0;
        tick();
        chk("s4_post_vo1", vo1, 0);
        vin = 1'b1; din = DW'('h33);
        tick();
        chk("s4_one_do1", do1, 'h33);
        din = DW'('h55); flush = 1'b1;
        tick();
        chk("s4_fl2_vo1", vo1, 0); chk("s4_fl2_do1", do1, 0);
        chk("s4_fl2_vo0", vo0, 0); chk("s4_fl2_do0", do0, 0);
        flush = 1'b0; vin = 1'b0;
        tick();
        chk("s4_fl2_post", vo1, 0);

        // 5: STALL with READY_IN high, then FLUSH&STALL
        do_reset();
        rin = 1'b1; vin = 1'b1; din = DW'('h77);
        tick();
        chk("s5_ld_do1", do1, 'h77); chk("s5_ld_do0", do0, 'h77);
        chk("s5_ld_bc1", bc1, 1);
        stall = 1'b1; vin = 1'b0;
        #1;
        chk("s5_ro0_stall", ro0, 0);
        tick();
        chk("s5_st1_do1", do1, 'h77); chk("s5_st1_do0", do0, 'h77);
        vin = 1'b1; din = DW'('h88);
        tick();
        chk("s5_st2_do1", do1, 'h77); chk("s5_st2_do0", do0, 'h77);
        chk("s5_st2_ro1", ro1, 0);
        chk("s5_st2_sc1", sc1, 2); chk("s5_st2_sc0", sc0, 2);
        flush = 1'b1; vin = 1'b0;
        tick();
        chk("s5_fs_vo1", vo1, 0); chk("s5_fs_vo0", vo0, 0);
        chk("s5_fs_ro1", ro1, 1); chk("s5_fs_ro0", ro0, 1);
        flush = 1'b0; stall = 1'b0;

        // 6: counter saturation
        do_reset();
        vin = 1'b1; din = DW'('h9);
        tick();
        vin = 1'b0;
        repeat (20) tick();
        chk("s6_sc4", sc4, 15); chk("s6_sc1", sc1, 20);
        chk("s6_vo4", vo4, 1);
        flush = 1'b1;
        tick();
        chk("s6_fl_vo4", vo4, 0); chk("s6_fl_do4", do4, 'h9);
        flush = 1'b0; rin = 1'b1;
        repeat (5) tick();
        chk("s6_bc4_5", bc4, 5); chk("s6_bc1_5", bc1, 5);
        repeat (12) tick();
        chk("s6_bc4_sat", bc4, 15); chk("s6_bc1_17", bc1, 17);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
